// File: rtl/cpu.sv
// Minimal core with the same bus ports as the team's RISC-V core: fetches bytes upward from
// address 0 while ready, stopping at a zero byte. Never writes.
module cpu (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  logic [31:0] pc;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc <= '0;
    end else if (rdy_in && !io_buffer_full && (mem_din != 8'h00)) begin
      pc <= pc + 32'd1;
    end
  end

  assign mem_a    = pc;
  assign mem_dout = mem_din;
  assign mem_wr   = 1'b0;

endmodule

// File: rtl/riscv_top.sv
// System top: reset conditioning, cpu core, 128 KiB byte RAM, memory-mapped I/O,
// 8N1 UART with TX/RX FIFOs and a halt LED.
module riscv_top #(
  parameter int unsigned SIM            = 0,
  parameter int unsigned SYS_CLK_FREQ   = 100000000,
  parameter int unsigned UART_BAUD_RATE = 115200,
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic EXCLK,
  input  logic btnC,
  output logic Tx,
  input  logic Rx,
  output logic led
);

  localparam int unsigned Div = SYS_CLK_FREQ / UART_BAUD_RATE;
  localparam int unsigned Fw  = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DivLast = 16'(Div - 1);
  localparam logic [15:0] DivHalf = 16'(Div / 2 - 1);

  // Reset: async assert, synchronised release, optional power-on hold.
  logic [3:0] por_cnt;
  logic [1:0] rst_sync;
  logic       rst, por_busy;

  assign por_busy = (SIM == 0) && (por_cnt != 4'hf);

  always_ff @(posedge EXCLK or posedge btnC) begin
    if (btnC) begin
      por_cnt  <= '0;
      rst_sync <= 2'b11;
    end else begin
      if (por_cnt != 4'hf) por_cnt <= por_cnt + 4'd1;
      rst_sync <= {rst_sync[0], por_busy};
    end
  end
  assign rst = rst_sync[1];

  // Core bus
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpu_wr, cpu_rdy, io_full, halted;

  assign cpu_rdy = ~halted;

  cpu u_cpu (
    .clk_in        (EXCLK),
    .rst_in        (rst),
    .rdy_in        (cpu_rdy),
    .mem_din       (cpu_din),
    .mem_dout      (cpu_dout),
    .mem_a         (cpu_a),
    .mem_wr        (cpu_wr),
    .io_buffer_full(io_full)
  );

  logic sel_io, tx_push, halt_set, rx_pop_req, cnt_rd;
  assign sel_io     = cpu_a[17:16] == 2'b11;
  assign tx_push    = sel_io &&  cpu_wr && (cpu_a[17:0] == 18'h30000);
  assign halt_set   = sel_io &&  cpu_wr && (cpu_a[17:0] == 18'h30004);
  assign rx_pop_req = sel_io && !cpu_wr && (cpu_a[17:0] == 18'h30000);
  assign cnt_rd     = sel_io && !cpu_wr && (cpu_a[17:0] == 18'h30004);

  // RAM
  logic [7:0] ram [2**RAM_ADDR_WIDTH];
  logic [7:0] ram_q;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  assign ram_addr = cpu_a[RAM_ADDR_WIDTH-1:0];

  always_ff @(posedge EXCLK) begin
    if (cpu_wr && !sel_io) ram[ram_addr] <= cpu_dout;
    ram_q <= ram[ram_addr];
  end

  // FIFOs: index 0 = TX, 1 = RX
  logic [1:0] f_push, f_pop, f_empty, f_full;
  logic [7:0] f_wdata [2];
  logic [7:0] f_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [7:0]    mem [FIFO_DEPTH];
    logic [Fw-1:0] wptr, rptr;
    logic [Fw:0]   cnt;
    logic          do_push, do_pop;

    assign do_push = f_push[g] && !f_full[g];
    assign do_pop  = f_pop[g] && !f_empty[g];

    always_ff @(posedge EXCLK or posedge rst) begin
      if (rst) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (do_push) wptr <= wptr + Fw'(1);
        if (do_pop)  rptr <= rptr + Fw'(1);
        cnt <= cnt + (Fw+1)'(do_push) - (Fw+1)'(do_pop);
      end
    end

    always_ff @(posedge EXCLK) begin
      if (do_push) mem[wptr] <= f_wdata[g];
    end

    assign f_empty[g] = cnt == '0;
    assign f_full[g]  = cnt == (Fw+1)'(FIFO_DEPTH);
    assign f_rdata[g] = mem[rptr];
  end

  // One slot of headroom for a write the core already has in flight.
  assign io_full = g_fifo[0].cnt >= (Fw+1)'(FIFO_DEPTH - 1);

  // I/O read path, halt flag, cycle counter
  logic [31:0] cycle_cnt;
  logic [7:0]  io_q;
  logic        is_io_q;

  always_ff @(posedge EXCLK or posedge rst) begin
    if (rst) begin
      io_q      <= '0;
      is_io_q   <= 1'b0;
      halted    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      is_io_q   <= sel_io;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (halt_set) halted <= 1'b1;
      if (rx_pop_req)  io_q <= f_empty[1] ? 8'h00 : f_rdata[1];
      else if (cnt_rd) io_q <= cycle_cnt[7:0];
      else             io_q <= 8'h00;
    end
  end

  assign cpu_din = is_io_q ? io_q : ram_q;
  assign led     = halted;

  logic unused_bits;
  assign unused_bits = ^{cpu_a[31:18], cycle_cnt[31:8]};

  typedef enum logic [1:0] {UIdle, UStart, UData, UStop} uart_st_e;

  // UART TX
  uart_st_e    tx_st_q, tx_st_d;
  logic [15:0] tx_baud_q, tx_baud_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_pop;

  always_ff @(posedge EXCLK or posedge rst) begin
    if (rst) begin
      tx_st_q   <= UIdle;
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_baud_q <= tx_baud_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
    end
  end

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_baud_d = (tx_st_q == UIdle) ? 16'd0 : tx_baud_q + 16'd1;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_pop    = 1'b0;
    case (tx_st_q)
      UIdle: if (!f_empty[0]) begin
        tx_pop  = 1'b1;
        tx_sh_d = f_rdata[0];
        tx_st_d = UStart;
      end
      UStart: if (tx_baud_q == DivLast) begin
        tx_baud_d = '0;
        tx_bit_d  = '0;
        tx_st_d   = UData;
      end
      UData: if (tx_baud_q == DivLast) begin
        tx_baud_d = '0;
        tx_sh_d   = tx_sh_q >> 1;
        tx_bit_d  = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_st_d = UStop;
      end
      UStop: if (tx_baud_q == DivLast) begin
        tx_baud_d = '0;
        // Chain straight into the next start bit when more data is queued.
        if (!f_empty[0]) begin
          tx_pop  = 1'b1;
          tx_sh_d = f_rdata[0];
          tx_st_d = UStart;
        end else begin
          tx_st_d = UIdle;
        end
      end
      default: tx_st_d = UIdle;
    endcase
  end

  assign Tx = (tx_st_q == UStart) ? 1'b0 : (tx_st_q == UData) ? tx_sh_q[0] : 1'b1;

  // UART RX; rx_sync_q[2] is the previous synchronised bit for edge detection
  logic [2:0]  rx_sync_q;
  logic        rx_bit, rx_fall, rx_push;
  uart_st_e    rx_st_q, rx_st_d;
  logic [15:0] rx_baud_q, rx_baud_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;

  assign rx_bit  = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] && !rx_sync_q[1];

  always_ff @(posedge EXCLK or posedge rst) begin
    if (rst) begin
      rx_sync_q <= 3'b111;
      rx_st_q   <= UIdle;
      rx_baud_q <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_sync_q <= {rx_sync_q[1:0], Rx};
      rx_st_q   <= rx_st_d;
      rx_baud_q <= rx_baud_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_baud_d = (rx_st_q == UIdle) ? 16'd0 : rx_baud_q + 16'd1;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_push   = 1'b0;
    case (rx_st_q)
      UIdle: if (rx_fall) rx_st_d = UStart;
      UStart: if (rx_baud_q == DivHalf) begin
        rx_baud_d = '0;
        rx_bit_d  = '0;
        rx_st_d   = rx_bit ? UIdle : UData;
      end
      UData: if (rx_baud_q == DivLast) begin
        rx_baud_d = '0;
        rx_sh_d   = {rx_bit, rx_sh_q[7:1]};
        rx_bit_d  = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = UStop;
      end
      UStop: if (rx_baud_q == DivLast) begin
        rx_push = rx_bit;
        rx_st_d = UIdle;
      end
      default: rx_st_d = UIdle;
    endcase
  end

  assign f_push[0]  = tx_push;
  assign f_pop[0]   = tx_pop;
  assign f_wdata[0] = cpu_dout;
  assign f_push[1]  = rx_push;
  assign f_pop[1]   = rx_pop_req;
  assign f_wdata[1] = rx_sh_q;

  if (SIM != 0) begin : g_sim
    always_ff @(posedge EXCLK) begin
      if (!rst && tx_push) $write("%c", cpu_dout);
      if (!rst && halt_set) begin
        $display("IO:Return");
        $finish;
      end
    end
  end

endmodule

// File: tb/tb_riscv_top.sv
// Bench for riscv_top: forces the core bus to act as the CPU and checks RAM, I/O and UART
// behaviour against expectations computed here.
`timescale 1ns/100ps
module tb_riscv_top;

  logic clk = 1'b0;
  logic btnc = 1'b1;
  logic rx = 1'b1;
  logic tx, led;

  riscv_top #(
    .SIM           (0),
    .SYS_CLK_FREQ  (8),
    .UART_BAUD_RATE(1),
    .RAM_ADDR_WIDTH(17),
    .FIFO_DEPTH    (16)
  ) dut (
    .EXCLK(clk),
    .btnC (btnc),
    .Tx   (tx),
    .Rx   (rx),
    .led  (led)
  );

  always #1 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic [31:0] bus_a = '0;
  logic [7:0]  bus_d = '0;
  logic        bus_w = 1'b0;
  logic [7:0]  ram_m [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #0.2;
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic w);
    bus_a = a;
    bus_d = d;
    bus_w = w;
    force dut.cpu_a    = bus_a;
    force dut.cpu_dout = bus_d;
    force dut.cpu_wr   = bus_w;
  endtask

  task automatic idle();
    drive(32'h0, 8'h00, 1'b0);
  endtask

  task automatic wait_rst_release(input string tag);
    int w = 0;
    while (dut.rst !== 1'b0 && w < 60) begin
      step(1);
      w++;
    end
    chk(tag, {31'd0, dut.rst}, 32'd0);
  endtask

  // Expected frame: start 0, data LSB first, stop 1; each bit 8 clocks, sampled mid-bit.
  task automatic check_frame(input logic [7:0] b, input int max_wait, input int exp_wait);
    int w = 0;
    logic e;
    while (tx !== 1'b0 && w < max_wait) begin
      step(1);
      w++;
    end
    if (tx !== 1'b0) begin
      chk("tx_start_timeout", {31'd0, tx}, 32'd0);
      return;
    end
    if (exp_wait >= 0) chk("tx_gap", w, exp_wait);
    step(4);
    for (int i = 0; i < 10; i++) begin
      e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      chk($sformatf("tx_bit%0d_byte%0h", i, b), {31'd0, tx}, {31'd0, e});
      if (i < 9) step(8);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    step(8);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(8);
    end
    rx = stop;
    step(8);
    rx = 1'b1;
    step(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, r;
    logic [7:0]  d, v1, v2, v3;
    logic [31:0] addrs [8];
    logic [7:0]  burst [16];
    logic [7:0]  rxb [3];

    // Reset
    step(10);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_led", {31'd0, led}, 32'd0);
    chk("rst_core", {31'd0, dut.rst}, 32'd1);
    chk("rst_fetch_addr", dut.cpu_a, 32'd0);
    step(15);
    btnc = 1'b0;
    wait_rst_release("rst_release");
    chk("fetch0", dut.cpu_a, 32'd0);
    idle();
    step(1);

    // RAM write then read next cycle
    drive(32'h0000_0100, 8'hA5, 1'b1);
    step(1);
    drive(32'h0000_0100, 8'h00, 1'b0);
    step(1);
    chk("ram_a5", {24'd0, dut.cpu_din}, 32'hA5);

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      a[17] = 1'b0;
      d = 8'($urandom);
      addrs[i] = a;
      ram_m[int'(a[16:0])] = d;
      drive(a, d, 1'b1);
      step(1);
    end
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      a = {r[31:18], 1'b0, addrs[i][16:0]};
      drive(a, 8'h00, 1'b0);
      step(1);
      chk("ram_rand", {24'd0, dut.cpu_din}, {24'd0, ram_m[int'(addrs[i][16:0])]});
    end
    idle();

    // Single TX byte
    drive(32'h0003_0000, 8'h41, 1'b1);
    step(1);
    idle();
    check_frame(8'h41, 20, -1);
    step(8);

    // Burst of 16 TX bytes; at most one has left the FIFO while they are queued
    for (int i = 0; i < 16; i++) burst[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          drive(32'h0003_0000, burst[i], 1'b1);
          step(1);
          if (i == 12) chk("io_full_low", {31'd0, dut.io_full}, 32'd0);
        end
        idle();
        chk("io_full_high", {31'd0, dut.io_full}, 32'd1);
      end
      begin
        for (int i = 0; i < 16; i++) check_frame(burst[i], 30, (i == 0) ? -1 : 4);
      end
    join
    step(8);
    chk("io_full_drained", {31'd0, dut.io_full}, 32'd0);

    // RX: one frame then read twice
    send_rx(8'h5A, 1'b1);
    drive(32'h0003_0000, 8'h00, 1'b0);
    step(1);
    chk("rx_5a", {24'd0, dut.cpu_din}, 32'h5A);
    step(1);
    chk("rx_empty", {24'd0, dut.cpu_din}, 32'h00);
    idle();

    // RX: random frames, FIFO order
    for (int i = 0; i < 3; i++) begin
      rxb[i] = 8'($urandom);
      send_rx(rxb[i], 1'b1);
    end
    drive(32'h0003_0000, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rx_order", {24'd0, dut.cpu_din}, {24'd0, rxb[i]});
    end
    step(1);
    chk("rx_order_empty", {24'd0, dut.cpu_din}, 32'h00);
    idle();

    // RX framing error drops the byte; a good frame afterwards still lands
    send_rx(8'($urandom), 1'b0);
    drive(32'h0003_0000, 8'h00, 1'b0);
    step(1);
    chk("rx_frame_err", {24'd0, dut.cpu_din}, 32'h00);
    idle();
    send_rx(8'hC3, 1'b1);
    drive(32'h0003_0000, 8'h00, 1'b0);
    step(1);
    chk("rx_after_err", {24'd0, dut.cpu_din}, 32'hC3);
    idle();

    // Cycle counter and unmapped I/O
    drive(32'h0003_0004, 8'h00, 1'b0);
    step(1);
    v1 = dut.cpu_din;
    step(1);
    v2 = dut.cpu_din;
    idle();
    step(4);
    drive(32'h0003_0004, 8'h00, 1'b0);
    step(1);
    v3 = dut.cpu_din;
    chk("cyc_inc", {24'd0, v2}, {24'd0, 8'(v1 + 8'd1)});
    chk("cyc_gap", {24'd0, v3}, {24'd0, 8'(v1 + 8'd6)});
    drive(32'hABC3_000C, 8'h00, 1'b0);
    step(1);
    chk("io_unmapped", {24'd0, dut.cpu_din}, 32'h00);
    idle();

    // Leave an RX byte and TX bytes queued, halt, then reset mid-frame
    send_rx(8'h99, 1'b1);
    drive(32'h0003_0000, 8'h00, 1'b1);
    step(1);
    drive(32'h0003_0000, 8'h55, 1'b1);
    step(1);
    drive(32'h0003_0004, 8'h77, 1'b1);
    step(1);
    idle();
    chk("led_halt", {31'd0, led}, 32'd1);
    chk("rdy_low", {31'd0, dut.cpu_rdy}, 32'd0);
    step(10);
    chk("tx_mid_frame", {31'd0, tx}, 32'd0);
    btnc = 1'b1;
    #0.3;
    chk("reset_tx_high", {31'd0, tx}, 32'd1);
    chk("reset_led_low", {31'd0, led}, 32'd0);
    chk("reset_rdy_high", {31'd0, dut.cpu_rdy}, 32'd1);
    step(3);
    btnc = 1'b0;
    wait_rst_release("rst_release2");
    idle();
    step(20);
    chk("tx_fifo_discarded", {31'd0, tx}, 32'd1);
    drive(32'h0003_0000, 8'h00, 1'b0);
    step(1);
    chk("rx_fifo_discarded", {24'd0, dut.cpu_din}, 32'h00);
    idle();
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
